// File: rtl/piece_lock_writer.sv
`default_nettype none
// ============================================================================
// Module      : piece_lock_writer
// Description : Locks a four-block falling piece into the board RAM. The
//               piece is validated (color, range, alignment, distinct cells)
//               when the request is taken. The four target cells are then
//               read back and checked for occupancy. If all four are empty,
//               the piece color is written to each of them.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               lock_req, color     - lock request and piece color (0 = empty)
//               x1..x4, y1..y4      - top-left pixel coordinates of each block
//               rd_addr / rd_data   - board RAM read port (1-cycle latency)
//               wr_en/wr_addr/wr_data - board RAM write port
//               busy, done, err     - status: busy, success pulse, reject pulse
// Revision    : 1.0 - initial release
// ============================================================================
module piece_lock_writer #(
    parameter int unsigned X0   = 200,
    parameter int unsigned CELL = 20,
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lock_req,
    input  logic [2:0] color,
    input  logic [9:0] x1,
    input  logic [9:0] x2,
    input  logic [9:0] x3,
    input  logic [9:0] x4,
    input  logic [9:0] y1,
    input  logic [9:0] y2,
    input  logic [9:0] y3,
    input  logic [9:0] y4,
    output logic [7:0] rd_addr,
    input  logic [2:0] rd_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [2:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned X_MAX = X0 + (COLS - 1) * CELL;
    localparam int unsigned Y_MAX = (ROWS - 1) * CELL;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    function automatic logic blk_ok(input logic [9:0] x, input logic [9:0] y);
        logic [31:0] xe;
        logic [31:0] ye;
        xe = {22'd0, x};
        ye = {22'd0, y};
        // The subtraction may wrap when xe < X0; the first term masks that case.
        return (xe >= X0) && (xe <= X_MAX) && (ye <= Y_MAX) &&
               (((xe - X0) % CELL) == 32'd0) && ((ye % CELL) == 32'd0);
    endfunction

    function automatic logic [7:0] blk_addr(input logic [9:0] x, input logic [9:0] y);
        logic [31:0] xe;
        logic [31:0] ye;
        xe = {22'd0, x};
        ye = {22'd0, y};
        return 8'((ye / CELL) * COLS + (xe - X0) / CELL);
    endfunction

    logic [3:0][9:0] blk_x;
    logic [3:0][9:0] blk_y;
    assign blk_x = {x4, x3, x2, x1};
    assign blk_y = {y4, y3, y2, y1};

    // Request-time validation and address mapping, taken straight from the inputs
    logic [3:0][7:0] req_addr;
    logic            req_ok;

    always_comb begin
        req_ok   = (color != 3'd0);
        req_addr = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = blk_addr(blk_x[i], blk_y[i]);
            if (!blk_ok(blk_x[i], blk_y[i])) req_ok = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (req_addr[i] == req_addr[j]) req_ok = 1'b0;
            end
        end
    end

    state_t          state_q, state_d;
    logic [3:0][7:0] addr_q, addr_d;
    logic [2:0]      color_q, color_d;
    logic [2:0]      cnt_q, cnt_d;    // next block index to issue (1-based progress)
    logic            coll_q, coll_d;  // an occupied cell has been seen
    logic [7:0]      rd_addr_q, rd_addr_d;
    logic            wr_en_q, wr_en_d;
    logic [7:0]      wr_addr_q, wr_addr_d;
    logic [2:0]      wr_data_q, wr_data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        color_d   = color_q;
        cnt_d     = cnt_q;
        coll_d    = coll_q;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lock_req) begin
                    color_d = color;
                    addr_d  = req_addr;
                    if (req_ok) begin
                        state_d   = S_CHECK;
                        rd_addr_d = req_addr[0];
                        cnt_d     = 3'd1;
                        coll_d    = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                // Read data lags the address by one cycle, so comparisons run
                // while cnt is 2..5 and the last one decides the outcome.
                if (cnt_q >= 3'd2) coll_d = coll_q | (rd_data != 3'd0);
                if (cnt_q < 3'd4) begin
                    rd_addr_d = addr_q[cnt_q[1:0]];
                    cnt_d     = cnt_q + 3'd1;
                end else if (cnt_q == 3'd4) begin
                    cnt_d = 3'd5;
                end else if (coll_d) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    state_d   = S_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[0];
                    wr_data_d = color_q;
                    cnt_d     = 3'd1;
                end
            end
            S_WRITE: begin
                if (cnt_q < 3'd4) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[cnt_q[1:0]];
                    cnt_d     = cnt_q + 3'd1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            color_q   <= 3'd0;
            cnt_q     <= 3'd0;
            coll_q    <= 1'b0;
            rd_addr_q <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 3'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            color_q   <= color_d;
            cnt_q     <= cnt_d;
            coll_q    <= coll_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_piece_lock_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piece_lock_writer
// Description : Directed bench for piece_lock_writer with a board RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piece_lock_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock_req = 1'b0;
    logic [2:0] color = 3'd0;
    logic [9:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
    logic [9:0] y1 = '0, y2 = '0, y3 = '0, y4 = '0;
    logic [7:0] rd_addr;
    logic [2:0] rd_data = 3'd0;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [2:0] wr_data;
    logic       busy, done, err;

    piece_lock_writer dut (
        .clk(clk), .rst_n(rst_n), .lock_req(lock_req), .color(color),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous read, optional occupied cell, bulk clear
    logic [2:0] mem [256];
    logic       mem_clr = 1'b0;
    logic       occ_en = 1'b0;
    logic [7:0] occ_addr = 8'd0;
    logic [2:0] occ_val = 3'd0;

    always @(posedge clk) begin
        rd_data <= (occ_en && rd_addr == occ_addr) ? occ_val : mem[rd_addr];
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 3'd0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Activity monitor
    int         wr_cnt, done_cnt, err_cnt, both_cnt;
    logic [7:0] wr_log [8];

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 8) wr_log[wr_cnt] = wr_addr;
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
        if (err) err_cnt = err_cnt + 1;
        if (done && err) both_cnt = both_cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 8; i++) wr_log[i] = 8'hFF;
    endtask

    task automatic clear_board();
        mem_clr = 1'b1;
        step();
        mem_clr = 1'b0;
    endtask

    task automatic set_piece(input logic [2:0] c,
                             input logic [9:0] ax1, input logic [9:0] ay1,
                             input logic [9:0] ax2, input logic [9:0] ay2,
                             input logic [9:0] ax3, input logic [9:0] ay3,
                             input logic [9:0] ax4, input logic [9:0] ay4);
        color = c;
        x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2;
        x3 = ax3; y3 = ay3; x4 = ax4; y4 = ay4;
    endtask

    task automatic std_piece();
        set_piece(3'd1, 10'd280, 10'd40, 10'd280, 10'd60, 10'd300, 10'd60, 10'd320, 10'd60);
    endtask

    // Immediate rejection: err in T+1, no reads, no writes, idle in T+2
    task automatic run_reject(input string tag);
        logic [7:0] rd_before;
        rd_before = rd_addr;
        clear_mon();
        lock_req = 1'b1;
        step();
        lock_req = 1'b0;
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_rd_hold"}, 32'(rd_addr), 32'(rd_before));
        step();
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_nowr"}, 32'(wr_cnt), 32'd0);
    endtask

    logic [7:0] exp_addr [4];

    initial begin
        exp_addr[0] = 8'd24; exp_addr[1] = 8'd34; exp_addr[2] = 8'd35; exp_addr[3] = 8'd36;
        both_cnt = 0;
        clear_mon();
        clear_board();
        step();

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);

        // Color-1 lock, request on the first edge after reset release
        std_piece();
        rst_n = 1'b1;
        clear_mon();
        lock_req = 1'b1;
        step();                                    // T+1
        lock_req = 1'b0;
        check("lock_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("lock_rd%0d", k), 32'(rd_addr), 32'(exp_addr[k]));
            step();                                // T+2 .. T+5
        end
        check("lock_nowr_t5", 32'(wr_en), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();                                // T+6 .. T+9
            check($sformatf("lock_wen%0d", k), 32'(wr_en), 32'd1);
            check($sformatf("lock_wa%0d", k), 32'(wr_addr), 32'(exp_addr[k]));
            check($sformatf("lock_wd%0d", k), 32'(wr_data), 32'd1);
        end
        step();                                    // T+10
        check("lock_done", 32'(done), 32'd1);
        check("lock_wen_off", 32'(wr_en), 32'd0);
        step();                                    // T+11
        check("lock_idle", 32'(busy), 32'd0);
        check("lock_done_off", 32'(done), 32'd0);
        check("lock_rd_hold", 32'(rd_addr), 32'd36);
        check("lock_mem35", 32'(mem[35]), 32'd1);

        // Collision on cell 35
        clear_board();
        occ_en = 1'b1; occ_addr = 8'd35; occ_val = 3'd5;
        clear_mon();
        lock_req = 1'b1;
        step();                                    // T+1
        lock_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("col_rd%0d", k), 32'(rd_addr), 32'(exp_addr[k]));
            step();
        end
        check("col_err_t5", 32'(err), 32'd0);
        step();                                    // T+6
        check("col_err", 32'(err), 32'd1);
        check("col_nodone", 32'(done), 32'd0);
        step();                                    // T+7
        check("col_idle", 32'(busy), 32'd0);
        check("col_nowr", 32'(wr_cnt), 32'd0);
        occ_en = 1'b0;

        // Range, alignment and color rejections
        std_piece(); x1 = 10'd400; run_reject("rng_x");
        std_piece(); y1 = 10'd45;  run_reject("align_y");
        std_piece(); color = 3'd0; run_reject("color0");
        std_piece(); x1 = 10'd300; y1 = 10'd40; x2 = 10'd300; y2 = 10'd40; run_reject("dup");

        // Second request while busy is ignored
        clear_board();
        std_piece();
        clear_mon();
        lock_req = 1'b1;
        step();                                    // T+1
        lock_req = 1'b0;
        step(); step();                            // T+3
        set_piece(3'd2, 10'd200, 10'd0, 10'd220, 10'd0, 10'd240, 10'd0, 10'd260, 10'd0);
        lock_req = 1'b1;
        step();                                    // T+4
        lock_req = 1'b0;
        for (int k = 0; k < 8; k++) step();        // through T+12
        check("busy_wrcnt", 32'(wr_cnt), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("busy_wa%0d", k), 32'(wr_log[k]), 32'(exp_addr[k]));
        check("busy_done", 32'(done_cnt), 32'd1);
        check("busy_noerr", 32'(err_cnt), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("busy_mem0", 32'(mem[0]), 32'd0);

        // Reset during T+7
        clear_board();
        std_piece();
        clear_mon();
        lock_req = 1'b1;
        step();                                    // T+1
        lock_req = 1'b0;
        for (int k = 0; k < 6; k++) step();        // T+7
        rst_n = 1'b0;
        #1;
        check("rstw_wen", 32'(wr_en), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        step(); step();
        check("rstw_wrcnt", 32'(wr_cnt), 32'd1);
        check("rstw_wa0", 32'(wr_log[0]), 32'd24);
        check("rstw_nodone", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        check("never_both", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piece_lock_writer.md
PIECE_LOCK_WRITER -- requirements
Module: piece_lock_writer

Interface
REQ-001 SHALL have parameter X0, default 200: pixel x of playfield column 0.
REQ-002 SHALL have parameter CELL, default 20: cell pitch in pixels, for both x and y.
REQ-003 SHALL have parameter COLS, default 10: playfield columns.
REQ-004 SHALL have parameter ROWS, default 24: playfield rows; row 0 at pixel y 0.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port lock_req, input, 1: request to lock the current piece into the board.
REQ-008 SHALL have port color, input, 3: piece color code, 3'b001-3'b111; 3'b000 is an empty cell.
REQ-009 SHALL have ports x1, x2, x3, x4, y1, y2, y3, y4, input, 10 each: top-left pixel coordinates of the piece's four blocks.
REQ-010 SHALL have port rd_addr, output, 8: board RAM read address.
REQ-011 SHALL have port rd_data, input, 3: board RAM read data, valid 1 cycle after rd_addr.
REQ-012 SHALL have port wr_en, output, 1: board RAM write strobe.
REQ-013 SHALL have port wr_addr, output, 8: board RAM write address.
REQ-014 SHALL have port wr_data, output, 3: board RAM write data.
REQ-015 SHALL have port busy, output, 1: high while not in IDLE.
REQ-016 SHALL have port done, output, 1: 1-cycle pulse on successful lock.
REQ-017 SHALL have port err, output, 1: 1-cycle pulse on rejected lock.

Function
REQ-018 SHALL map each block to col=(x-X0)/CELL, row=y/CELL, and board address = row*COLS+col (8 bits).
REQ-019 SHALL implement FSM states IDLE, CHECK, WRITE, DONE, ERR.
REQ-020 SHALL, in IDLE, on lock_req=1 (cycle T), latch color and all 8 coordinates and set busy in T+1.
REQ-021 SHALL reject the request, going to ERR with err=1 in T+1 and issuing no reads or writes, if any of the following holds:
- color==0;
- any x is outside [X0, X0+(COLS-1)*CELL];
- any y exceeds (ROWS-1)*CELL;
- any (x-X0) or y is not a multiple of CELL;
- any two blocks map to the same address.
REQ-022 SHALL otherwise enter CHECK, driving rd_addr for blocks 1..4 in cycles T+1..T+4.
REQ-023 SHALL compare rd_data against zero in cycles T+2..T+5.
REQ-024 SHALL leave CHECK at T+5 and go to ERR (err=1 at T+6, no writes) if any compared rd_data is nonzero.
REQ-025 SHALL, if all four compared cells are zero, enter WRITE with wr_en=1, wr_addr = block k address, and wr_data = latched color in cycles T+6..T+9, for k=1..4 in order.
REQ-026 SHALL pulse done=1 in T+10 (DONE state), then return to IDLE.
REQ-027 SHALL make ERR and DONE last exactly one cycle each, returning to IDLE the next cycle, where busy=0.
REQ-028 SHALL ignore lock_req while busy=1, with no queuing.
REQ-029 SHALL keep the latched coordinates and color stable for the whole transaction, regardless of input changes.
REQ-030 SHALL hold wr_en=0 outside WRITE, and SHALL hold rd_addr at its last value outside CHECK.
REQ-031 SHALL never assert done and err in the same cycle.

Reset
REQ-032 SHALL, while rst_n=0, immediately force state=IDLE and busy=0, done=0, err=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0.
REQ-033 SHALL abort any in-flight transaction on reset with no further writes; writes already issued stay in the board.
REQ-034 SHALL accept a new lock_req on the first rising edge after rst_n deasserts.

Verification
REQ-035 Color-1 lock:
- stimulus: empty board; color=1; (280,40), (280,60), (300,60), (320,60);
- response: wr_en at T+6..T+9, wr_addr 24, 34, 35, 36, wr_data=1; done at T+10.
REQ-036 Collision:
- stimulus: cell 35 preset to 5; same request as REQ-035;
- response: rd_addr 24, 34, 35, 36 at T+1..T+4; err at T+6; wr_en never asserted.
REQ-037 Range and alignment:
- stimulus A: x1=400 -> response: err at T+1, no rd/wr activity;
- stimulus B: y1=45 -> response: err at T+1, no rd/wr activity;
- stimulus C: color=0 -> response: err at T+1, no rd/wr activity.
REQ-038 Duplicate block:
- stimulus: x2,y2 equal to x1,y1 = (300,40);
- response: err at T+1, no writes.
REQ-039 Busy ignore:
- stimulus: second lock_req at T+3 with different coordinates;
- response: only the first piece's four writes occur, with one done.
REQ-040 Reset mid-write:
- stimulus: rst_n low during T+7;
- response: wr_en=0 immediately; exactly 1 write (addr 24) is observed; busy=0; no done.
